// File: rtl/timer_a_ctrl_if.sv
// Register bus and datapath control signals between the Timer_A controller
// and its host / counter datapath.
interface timer_a_ctrl_if;
  logic       i_we;
  logic [1:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;
  logic [7:0] i_ta;
  logic       o_tick;
  logic       o_dir;
  logic       o_clr;
  logic [7:0] o_tac;
  logic       o_irq;

  modport slave (
    input  i_we, i_addr, i_wdata, i_ta,
    output o_rdata, o_tick, o_dir, o_clr, o_tac, o_irq
  );

  modport master (
    output i_we, i_addr, i_wdata, i_ta,
    input  o_rdata, o_tick, o_dir, o_clr, o_tac, o_irq
  );
endinterface

// File: rtl/timer_a_ctrl.sv
// Timer_A control block: register file, prescaler and run-state FSM that
// drive tick/clear/direction into an external 8-bit counter datapath.
module timer_a_ctrl (
  input  logic           i_clk,
  input  logic           i_rst_n,
  timer_a_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_UP = 2'd1,
    ST_RUN_DN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] tactl_q, tactl_d;
  logic [7:0] tac_q, tac_d;
  logic       taifg_q, taifg_d;
  logic       taie_q, taie_d;
  logic [3:0] ps_q, ps_d;

  logic       ctl_wr, tac_wr, st_wr;
  logic [3:0] div_n;
  logic [1:0] mode;
  logic       en, running, tick, terminal, ctl_stop;
  logic       clr, dir, taifg_set;
  logic       unused_wdata;

  assign ctl_wr = bus.i_we && (bus.i_addr == 2'd0);
  assign tac_wr = bus.i_we && (bus.i_addr == 2'd1);
  assign st_wr  = bus.i_we && (bus.i_addr == 2'd2);

  assign mode    = tactl_q[6:5];
  assign en      = tactl_q[4];
  assign div_n   = (tactl_q[3:0] == 4'd0) ? 4'd1 : tactl_q[3:0];
  assign running = (state_q != ST_IDLE);
  assign tick    = running && (ps_q == (div_n - 4'd1));

  // A TACTL write that disables the timer or changes MODE drops back to IDLE.
  assign ctl_stop = ctl_wr && (!bus.i_wdata[4] || (bus.i_wdata[6:5] == 2'b00) ||
                               (bus.i_wdata[6:5] != mode));

  always_comb begin
    terminal = 1'b0;
    if (tick) begin
      case (mode)
        2'b01:   terminal = (bus.i_ta == tac_q);
        2'b10:   terminal = (bus.i_ta == 8'hFF);
        2'b11:   terminal = (state_q == ST_RUN_UP) ? (bus.i_ta == tac_q)
                                                   : (bus.i_ta == 8'h00);
        default: terminal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    clr       = 1'b0;
    dir       = (state_q != ST_RUN_DN);
    taifg_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ps_d = 4'd0;
        if (en && (mode != 2'b00) && !ctl_wr) begin
          state_d = ST_RUN_UP;
          clr     = 1'b1;
        end
      end
      ST_RUN_UP, ST_RUN_DN: begin
        ps_d = tick ? 4'd0 : ps_q + 4'd1;
        if (terminal) begin
          if (mode == 2'b11) begin
            // The turning-point tick already counts in the new direction,
            // so the datapath reverses at TAC / 00h instead of overshooting.
            state_d   = (state_q == ST_RUN_UP) ? ST_RUN_DN : ST_RUN_UP;
            dir       = (state_q == ST_RUN_DN);
            taifg_set = (state_q == ST_RUN_DN);
            ps_d      = 4'd0;
          end else begin
            clr       = 1'b1;
            taifg_set = 1'b1;
          end
        end
        if (ctl_wr) begin
          ps_d = 4'd0;
          if (ctl_stop) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ps_d    = 4'd0;
      end
    endcase
  end

  always_comb begin
    tactl_d = ctl_wr ? bus.i_wdata[6:0] : tactl_q;
    tac_d   = tac_wr ? bus.i_wdata : tac_q;
    taie_d  = st_wr ? bus.i_wdata[1] : taie_q;
    taifg_d = taifg_q;
    if (taifg_set) begin
      taifg_d = 1'b1;
    end else if (st_wr && bus.i_wdata[0]) begin
      taifg_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      tactl_q <= 7'd0;
      tac_q   <= 8'd0;
      taifg_q <= 1'b0;
      taie_q  <= 1'b0;
      ps_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      tactl_q <= tactl_d;
      tac_q   <= tac_d;
      taifg_q <= taifg_d;
      taie_q  <= taie_d;
      ps_q    <= ps_d;
    end
  end

  always_comb begin
    case (bus.i_addr)
      2'd0:    bus.o_rdata = {1'b0, tactl_q};
      2'd1:    bus.o_rdata = tac_q;
      2'd2:    bus.o_rdata = {6'd0, taie_q, taifg_q};
      default: bus.o_rdata = bus.i_ta;
    endcase
  end

  assign bus.o_tick = tick;
  assign bus.o_clr  = clr;
  assign bus.o_dir  = dir;
  assign bus.o_tac  = tac_q;
  assign bus.o_irq  = taifg_q & taie_q;

  assign unused_wdata = bus.i_wdata[7];

endmodule

// File: tb/tb_timer_a_ctrl.sv
// Bench for timer_a_ctrl: directed scenarios plus random register traffic
// checked cycle by cycle against a behavioural model and an 8-bit counter.
module tb_timer_a_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  timer_a_ctrl_if bus();

  timer_a_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: registers, run/direction and cycles elapsed in the tick period.
  logic [6:0] m_ctl;
  logic [7:0] m_tac;
  bit         m_ifg, m_ie, m_run, m_down;
  int         m_cnt;
  logic [7:0] ta;

  assign bus.i_ta = ta;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [6:0] ctl);
    return (ctl[3:0] == 4'd0) ? 1 : int'(ctl[3:0]);
  endfunction

  task automatic model_reset();
    m_ctl = '0; m_tac = '0; m_ifg = 0; m_ie = 0;
    m_run = 0; m_down = 0; m_cnt = 0; ta = 8'd0;
  endtask

  task automatic cycle(input bit we, input logic [1:0] addr, input logic [7:0] wd);
    logic [1:0] mode;
    logic [7:0] exp_rd;
    bit tick, term, start, clr, dir, cw, stop, down0;
    int n;
    @(negedge clk);
    bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wd;
    if (we) $display("write addr=%0d data=%02h ta=%02h", addr, wd, ta);
    mode  = m_ctl[6:5];
    n     = div_of(m_ctl);
    tick  = m_run && (m_cnt == n - 1);
    term  = tick && (((mode == 2'b01) && (ta == m_tac)) ||
                     ((mode == 2'b10) && (ta == 8'hFF)) ||
                     ((mode == 2'b11) && !m_down && (ta == m_tac)) ||
                     ((mode == 2'b11) && m_down && (ta == 8'h00)));
    cw    = we && (addr == 2'd0);
    start = !m_run && m_ctl[4] && (mode != 2'b00) && !cw;
    clr   = start || (term && (mode != 2'b11));
    dir   = (term && (mode == 2'b11)) ? m_down : !m_down;
    case (addr)
      2'd0:    exp_rd = {1'b0, m_ctl};
      2'd1:    exp_rd = m_tac;
      2'd2:    exp_rd = {6'd0, m_ie, m_ifg};
      default: exp_rd = ta;
    endcase
    #2;
    check_eq("tick",  bus.o_tick,  tick);
    check_eq("clr",   bus.o_clr,   clr);
    check_eq("dir",   bus.o_dir,   dir);
    check_eq("irq",   bus.o_irq,   m_ifg & m_ie);
    check_eq("tac",   bus.o_tac,   m_tac);
    check_eq("rdata", bus.o_rdata, exp_rd);
    @(posedge clk);
    #1;
    down0 = m_down;
    if (m_run) begin
      stop = cw && (!wd[4] || (wd[6:5] == 2'b00) || (wd[6:5] != mode));
      if (stop) begin
        m_run = 0; m_down = 0; m_cnt = 0;
      end else if (term && (mode == 2'b11)) begin
        m_down = !m_down; m_cnt = 0;
      end else if (cw || tick) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (start) begin
      m_run = 1; m_down = 0; m_cnt = 0;
    end
    if (term && ((mode != 2'b11) || down0)) m_ifg = 1;
    else if (we && (addr == 2'd2) && wd[0]) m_ifg = 0;
    if (we && (addr == 2'd2)) m_ie = wd[1];
    if (cw) m_ctl = wd[6:0];
    if (we && (addr == 2'd1)) m_tac = wd;
    if (clr) ta = 8'd0;
    else if (tick) ta = dir ? ta + 8'd1 : ta - 8'd1;
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 2'(i % 4), 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.i_we = 1'b0; bus.i_addr = 2'd0; bus.i_wdata = 8'h00;
    #1;
    $display("reset asserted");
    check_eq("rst_tick",  bus.o_tick,  8'd0);
    check_eq("rst_clr",   bus.o_clr,   8'd0);
    check_eq("rst_dir",   bus.o_dir,   8'd1);
    check_eq("rst_irq",   bus.o_irq,   8'd0);
    check_eq("rst_tac",   bus.o_tac,   8'd0);
    check_eq("rst_tactl", bus.o_rdata, 8'd0);
    bus.i_addr = 2'd2;
    #1;
    check_eq("rst_status", bus.o_rdata, 8'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    bus.i_we = 1'b0; bus.i_addr = 2'd0; bus.i_wdata = 8'h00;
    model_reset();
    do_reset();
    idle_cycles(4);

    // Up mode, DIV=1, TAC=3.
    cycle(1'b1, 2'd1, 8'h03);
    cycle(1'b1, 2'd0, 8'h31);
    idle_cycles(20);
    // Disable while running.
    cycle(1'b1, 2'd0, 8'h21);
    idle_cycles(10);

    // Up/down, DIV=4, TAC=2.
    cycle(1'b1, 2'd1, 8'h02);
    cycle(1'b1, 2'd0, 8'h74);
    idle_cycles(60);

    // Continuous with interrupt enabled; mode change restarts from IDLE.
    cycle(1'b1, 2'd2, 8'h02);
    cycle(1'b1, 2'd0, 8'h51);
    idle_cycles(270);
    cycle(1'b1, 2'd2, 8'h03);
    idle_cycles(3);
    // Software clear landing on the set cycle.
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_run && (m_cnt == div_of(m_ctl) - 1) && (ta == 8'hFF)) begin
        cycle(1'b1, 2'd2, 8'h03);
        found = 1;
      end else begin
        cycle(1'b0, 2'd2, 8'h00);
      end
    end
    check_eq("clr_on_set_reached", 8'(found), 8'd1);
    idle_cycles(3);

    // TAC=0 in up mode.
    cycle(1'b1, 2'd1, 8'h00);
    cycle(1'b1, 2'd0, 8'h31);
    idle_cycles(12);

    // TAC lowered below the running count.
    cycle(1'b1, 2'd1, 8'h0A);
    idle_cycles(8);
    cycle(1'b1, 2'd1, 8'h03);
    idle_cycles(260);

    // Reset mid-prescale, then stays idle.
    cycle(1'b1, 2'd0, 8'h34);
    idle_cycles(6);
    do_reset();
    idle_cycles(10);

    // Random register traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] a;
      logic [7:0] d;
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 9) == 0) begin
        case (a)
          2'd0: d = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 4))};
          2'd1: d = 8'($urandom_range(0, 15));
          default: d = 8'($urandom_range(0, 255));
        endcase
        cycle(1'b1, a, d);
      end else begin
        cycle(1'b0, a, 8'h00);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
